fir_result_reader: RTL and testbench

//  Read side of the FIR result register. Each enable pulse strobes a 32-bit word

---
 rtl/fir_result_reader.sv | 196 +++++++++++++++++++
 tb/tb_fir_result_reader.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fir_result_reader.sv
// fir_result_reader: read side of the FIR result register.
// Captures a DATA_W word on each enable strobe into a DEPTH-entry FIFO and
// unloads every word as NSLICE = DATA_W/OUT_W slices (LS slice first) over a
// valid/ready stream. Back-to-back words stream without a bubble.
//
// Ports:
//   clk        clock, all logic on posedge
//   reset      synchronous, active-high
//   enable     write strobe, data_in captured when 1
//   data_in    FIR result word
//   out_valid  out_data holds a valid slice
//   out_ready  consumer accepts the slice
//   out_data   current slice
//   out_last   high on the final slice of a word
//   level      words held, including the word being unloaded
//   overflow   sticky: a strobe was dropped because the FIFO was full
//   out_parity (FIR_RD_PARITY_EN) ^out_data, 0 while out_valid=0
//   parity_err (FIR_RD_PARITY_EN) sticky: stored parity mismatched at pop
//
// Optional feature macro: FIR_RD_PARITY_EN (per-entry parity bit + checks).
module fir_result_reader #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned OUT_W  = 16,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [DATA_W-1:0]        data_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OUT_W-1:0]         out_data,
   output logic                     out_last,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow
`ifdef FIR_RD_PARITY_EN
   ,
   output logic                     out_parity,
   output logic                     parity_err
`endif
);

   localparam int unsigned NSLICE = DATA_W / OUT_W;
   localparam int unsigned AW     = $clog2(DEPTH);
   localparam int unsigned LW     = AW + 1;
   localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } state_t;

   // Extract slice idx of a word.
   function automatic logic [OUT_W-1:0] slice_of(input logic [DATA_W-1:0] w,
                                                 input logic [KW-1:0]     idx);
      return w[idx*OUT_W +: OUT_W];
   endfunction

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]     level_q, level_d;
   logic [KW-1:0]     k_q;
   state_t            state_q;
   logic              out_valid_q, out_last_q, overflow_q;
   logic [OUT_W-1:0]  out_data_q;

   logic              xfer, pop, push;
   logic [DATA_W-1:0] head, next_head;

   assign xfer = out_valid_q & out_ready;
   assign pop  = xfer & out_last_q;
   assign push = enable & ((level_q != LW'(DEPTH)) | pop);
   assign head = mem_q[rd_ptr_q];
   // With one word left and a concurrent push, the next head is still in flight.
   assign next_head = (level_q == LW'(1)) ? data_in : mem_q[rd_ptr_q + AW'(1)];

   // Occupancy update.
   always_comb begin
      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // FIFO storage; stale entries after reset are ignored via the pointers.
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         mem_q[wr_ptr_q] <= data_in;
      end
   end

`ifdef FIR_RD_PARITY_EN
   logic             par_mem_q [DEPTH];
   logic             out_parity_q, parity_err_q;

   always_ff @(posedge clk) begin
      if (!reset && push) begin
         par_mem_q[wr_ptr_q] <= ^data_in;
      end
   end

   // Parity checked on pop, parity output registered with out_data.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_parity_q <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         if (pop && (par_mem_q[rd_ptr_q] != ^head)) begin
            parity_err_q <= 1'b1;
         end
         case (state_q)
            S_IDLE: begin
               if (level_q != '0) out_parity_q <= ^slice_of(head, '0);
            end
            S_SEND: begin
               if (xfer) begin
                  if (!out_last_q)           out_parity_q <= ^slice_of(head, k_q + KW'(1));
                  else if (level_d != '0)    out_parity_q <= ^slice_of(next_head, '0);
                  else                       out_parity_q <= 1'b0;
               end
            end
            default: out_parity_q <= 1'b0;
         endcase
      end
   end

   assign out_parity = out_parity_q;
   assign parity_err = parity_err_q;
`endif

   // Pointers, flags and the unload FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         k_q         <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         overflow_q  <= 1'b0;
      end else begin
         level_q <= level_d;
         if (push)           wr_ptr_q   <= wr_ptr_q + AW'(1);
         if (pop)            rd_ptr_q   <= rd_ptr_q + AW'(1);
         if (enable && !push) overflow_q <= 1'b1;

         case (state_q)
            S_IDLE: begin
               if (level_q != '0) begin
                  state_q     <= S_SEND;
                  out_valid_q <= 1'b1;
                  k_q         <= '0;
                  out_data_q  <= slice_of(head, '0);
                  out_last_q  <= (NSLICE == 1);
               end
            end
            S_SEND: begin
               if (xfer) begin
                  if (!out_last_q) begin
                     k_q        <= k_q + KW'(1);
                     out_data_q <= slice_of(head, k_q + KW'(1));
                     out_last_q <= ((k_q + KW'(1)) == KW'(NSLICE - 1));
                  end else begin
                     k_q <= '0;
                     if (level_d != '0) begin
                        out_data_q <= slice_of(next_head, '0);
                        out_last_q <= (NSLICE == 1);
                     end else begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        out_data_q  <= '0;
                     end
                  end
               end
            end
            default: begin
               state_q     <= S_IDLE;
               out_valid_q <= 1'b0;
               out_last_q  <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign level     = level_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_fir_result_reader.sv
// Bench for fir_result_reader: directed scenarios plus random traffic, all
// outputs compared every cycle against a word-queue reference model.
module tb_fir_result_reader;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned OUT_W  = 16;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned NS     = DATA_W / OUT_W;

   logic              clk = 1'b0;
   logic              reset, enable, out_ready;
   logic [DATA_W-1:0] data_in;
   logic              out_valid, out_last, overflow;
   logic [OUT_W-1:0]  out_data;
   logic [2:0]        level;
`ifdef FIR_RD_PARITY_EN
   logic              out_parity, parity_err;
`endif

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Reference model: queue of accepted words, slice index, valid flag.
   logic [DATA_W-1:0] mq[$];
   int unsigned       mk;
   bit                mvld, movf;

   fir_result_reader #(.DATA_W(DATA_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .data_in   (data_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .level     (level),
      .overflow  (overflow)
`ifdef FIR_RD_PARITY_EN
      ,
      .out_parity(out_parity),
      .parity_err(parity_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [OUT_W-1:0] exp_slice();
      logic [DATA_W-1:0] w;
      if (!mvld) return '0;
      w = mq[0] >> (mk * OUT_W);
      return w[OUT_W-1:0];
   endfunction

   task automatic model_update(input bit en, input logic [DATA_W-1:0] din,
                               input bit rdy, input bit rst);
      int unsigned n0;
      bit xf, pp, ps;
      if (rst) begin
         mq.delete();
         mk = 0; mvld = 0; movf = 0;
      end else begin
         n0 = mq.size();
         xf = mvld && rdy;
         pp = xf && (mk == NS - 1);
         ps = en && ((n0 < DEPTH) || pp);
         if (en && !ps) movf = 1;
         if (xf) begin
            if (pp) begin
               void'(mq.pop_front());
               mk = 0;
            end else begin
               mk++;
            end
         end
         if (ps) mq.push_back(din);
         mvld = mvld ? (mq.size() > 0) : (n0 > 0);
      end
   endtask

   task automatic compare_all();
      logic [OUT_W-1:0] es;
      es = exp_slice();
      check("out_valid", 32'(out_valid), 32'(mvld));
      check("out_data",  32'(out_data),  32'(es));
      check("out_last",  32'(out_last),  32'(mvld && (mk == NS - 1)));
      check("level",     32'(level),     32'(mq.size()));
      check("overflow",  32'(overflow),  32'(movf));
`ifdef FIR_RD_PARITY_EN
      check("out_parity", 32'(out_parity), 32'(^es));
      check("parity_err", 32'(parity_err), 32'h0);
`endif
   endtask

   // One clock: drive on negedge, update model at posedge, sample 1 later.
   task automatic step(input bit en, input logic [DATA_W-1:0] din,
                       input bit rdy, input bit rst);
      @(negedge clk);
      enable = en; data_in = din; out_ready = rdy; reset = rst;
      @(posedge clk);
      model_update(en, din, rdy, rst);
      #1;
      compare_all();
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; out_ready = 1'b0; data_in = '0;
      mk = 0; mvld = 0; movf = 0;

      // Reset state.
      step(0, 0, 0, 1);
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_level", 32'(level), 32'h0);

      // Single word, ready high.
      step(1, 32'hDEAD_BEEF, 1, 0);
      check("t1_lat0", 32'(out_valid), 32'h0);
      step(0, 0, 1, 0);
      check("t1_s0", 32'(out_data), 32'hBEEF);
      check("t1_l0", 32'(out_last), 32'h0);
      step(0, 0, 1, 0);
      check("t1_s1", 32'(out_data), 32'hDEAD);
      check("t1_l1", 32'(out_last), 32'h1);
      step(0, 0, 1, 0);
      check("t1_end", 32'(out_valid), 32'h0);

      // Fill to full, then overflow, then drain.
      for (int i = 1; i <= 4; i++) step(1, 32'(i), 0, 0);
      check("t2_full", 32'(level), 32'h4);
      check("t2_noovf", 32'(overflow), 32'h0);
      step(1, 32'd5, 0, 0);
      check("t2_lvl", 32'(level), 32'h4);
      check("t2_ovf", 32'(overflow), 32'h1);
      for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
      check("t2_empty", 32'(level), 32'h0);

      // Full FIFO with simultaneous pop and push.
      step(0, 0, 0, 1);
      for (int i = 0; i < 4; i++) step(1, 32'hA000 + 32'(i), 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 1, 0);
      check("t3_last", 32'(out_last), 32'h1);
      step(1, 32'h1234_5678, 1, 0);
      check("t3_lvl", 32'(level), 32'h4);
      check("t3_ovf", 32'(overflow), 32'h0);

      // Stalls mid-word, then continuous streaming.
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 1, 0);
      for (int i = 0; i < 12; i++) step(1, $urandom, 1, 0);
      for (int i = 0; i < 12; i++) step(0, 0, 1, 0);

      // Reset mid-word.
      step(1, 32'hCAFE_F00D, 1, 0);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 1);
      check("t5_valid", 32'(out_valid), 32'h0);
      check("t5_level", 32'(level), 32'h0);
      step(1, 32'h0000_0001, 1, 0);
      step(0, 0, 1, 0);
      check("t5_s0", 32'(out_data), 32'h0001);
      check("t5_l0", 32'(out_last), 32'h0);
`ifdef FIR_RD_PARITY_EN
      check("t6_par0", 32'(out_parity), 32'h1);
`endif
      step(0, 0, 1, 0);
      check("t5_s1", 32'(out_data), 32'h0000);
`ifdef FIR_RD_PARITY_EN
      check("t6_par1", 32'(out_parity), 32'h0);
`endif

      // Random traffic with occasional reset.
      for (int i = 0; i < 3000; i++) begin
         step(bit'($urandom_range(0, 99) < 45), $urandom,
              bit'($urandom_range(0, 99) < 60), bit'($urandom_range(0, 199) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
